// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC, combinational-ROM fetch, 2-entry instruction queue
// drained by decode, redirect steering and a sticky fetch-fault state.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [24:0] ROM_BASE = 25'd0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_rd,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic        i_halt,
    output logic        o_fault,
    output logic [31:0] o_fault_addr,
    output logic [15:0] o_retired_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_q_data [2];
    logic [31:0] r_q_pc   [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_fault;
    logic [31:0] r_fault_addr;
    logic [15:0] r_retired_cnt;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_fault_addr_next;
    logic        w_valid;
    logic        w_pop_req;
    logic        w_attempt;
    logic        w_illegal;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_tail;

    assign w_valid   = (r_count != 2'd0);
    assign w_pop_req = w_valid && i_instr_ready;
    assign w_attempt = (r_state == ST_RUN) && !i_redirect_valid && ((r_count < 2'd2) || w_pop_req);
    assign w_illegal = w_attempt && (r_pc[31:7] != ROM_BASE);
    // Slot after the occupied entries; equals the head when full, which is only written alongside a pop.
    assign w_tail    = r_head ^ r_count[0];

    // Next-state and per-cycle queue/PC control, in priority order fault > redirect > halt > fetch.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_fault_addr_next = r_fault_addr;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_flush           = 1'b0;
        case (r_state)
            ST_RUN, ST_HALT: begin
                if (i_redirect_valid && (i_redirect_target[1:0] != 2'b00)) begin
                    w_state_next      = ST_FAULT;
                    w_fault_addr_next = i_redirect_target;
                    w_flush           = 1'b1;
                end else if (i_redirect_valid) begin
                    w_pc_next = i_redirect_target;
                    w_flush   = 1'b1;
                end else if (w_illegal) begin
                    w_state_next      = ST_FAULT;
                    w_fault_addr_next = r_pc;
                    w_pop             = w_pop_req;
                end else if (r_state == ST_HALT) begin
                    w_state_next = i_halt ? ST_HALT : ST_RUN;
                    w_pop        = w_pop_req;
                end else if (i_halt) begin
                    w_state_next = ST_HALT;
                    w_pop        = w_pop_req;
                end else begin
                    w_push    = w_attempt;
                    w_pop     = w_pop_req;
                    w_pc_next = w_attempt ? (r_pc + 32'd4) : r_pc;
                end
            end
            ST_FAULT: begin
                w_pop = w_pop_req;
            end
            default: begin
                w_state_next = ST_FAULT;
                w_flush      = 1'b1;
            end
        endcase
    end

    // State, queue and counters; the active-low reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_fault       <= 1'b0;
            r_fault_addr  <= 32'h0;
            r_retired_cnt <= 16'h0;
            for (int i = 0; i < 2; i++) begin
                r_q_data[i] <= 32'h0;
                r_q_pc[i]   <= 32'h0;
            end
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_fault_addr <= w_fault_addr_next;
            r_fault      <= (w_state_next == ST_FAULT);
            if (w_flush) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
            end else begin
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                r_head  <= r_head ^ w_pop;
            end
            if (w_push) begin
                r_q_data[w_tail] <= i_imem_data;
                r_q_pc[w_tail]   <= r_pc;
            end
            if (w_pop) begin
                r_retired_cnt <= r_retired_cnt + 16'd1;
            end
        end
    end

    assign o_imem_addr   = i_reset ? r_pc : 32'h0;
    assign o_imem_rd     = i_reset && w_push;
    assign o_instr_valid = i_reset && w_valid;
    assign o_instr       = (i_reset && w_valid) ? r_q_data[r_head] : 32'h0;
    assign o_instr_pc    = (i_reset && w_valid) ? r_q_pc[r_head] : 32'h0;
    assign o_fault       = r_fault;
    assign o_fault_addr  = r_fault_addr;
    assign o_retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a PC scoreboard is filled with the expected
// delivery order and drained whenever decode accepts an instruction.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        fault;
    logic [31:0] fault_addr;
    logic [15:0] retired_cnt;

    int          n_checks;
    int          n_pass;
    logic [31:0] sb_q [$];
    logic        rd_s;
    logic [31:0] addr_s;
    logic        vld_s;

    ifetch_unit dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .o_imem_addr       (imem_addr),
        .o_imem_rd         (imem_rd),
        .i_imem_data       (imem_data),
        .o_instr           (instr),
        .o_instr_pc        (instr_pc),
        .o_instr_valid     (instr_valid),
        .i_instr_ready     (instr_ready),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_halt            (halt),
        .o_fault           (fault),
        .o_fault_addr      (fault_addr),
        .o_retired_cnt     (retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_data = rom_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, score any accepted pop.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rt, input logic hlt,
                       input logic flush, output logic rd_o, output logic [31:0] addr_o,
                       output logic valid_o);
        logic [31:0] exp_pc;
        instr_ready     = rdy;
        redirect_valid  = rv;
        redirect_target = rt;
        halt            = hlt;
        #1;
        rd_o    = imem_rd;
        addr_o  = imem_addr;
        valid_o = instr_valid;
        if (instr_valid && rdy && !flush) begin
            check("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                check("instr_pc", instr_pc, exp_pc);
                check("instr", instr, rom_word(exp_pc));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        logic        r;
        logic [31:0] a;
        logic        v;
        for (int k = 0; k < n; k++) cyc(rdy, 1'b0, 32'h0, 1'b0, 1'b0, r, a, v);
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt            = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_rd", {31'd0, imem_rd}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        check("rst_retired", {16'd0, retired_cnt}, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        sb_q.delete();
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Streaming with ready held high.
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, rd_s, addr_s, vld_s);
        check("t1_c0_rd", {31'd0, rd_s}, 32'd1);
        check("t1_c0_addr", addr_s, 32'h0);
        check("t1_c0_valid", {31'd0, vld_s}, 32'd0);
        for (int i = 0; i < 9; i++) sb_q.push_back(32'(i * 4));
        run(9, 1'b1);
        check("t1_retired", {16'd0, retired_cnt}, 32'd9);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // Backpressure: queue fills, fetch stalls at pc 8.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rd_s, addr_s, vld_s);
            if (i >= 2) begin
                check("t2_stall_rd", {31'd0, rd_s}, 32'd0);
                check("t2_stall_pc", addr_s, 32'h8);
            end
        end
        for (int i = 0; i < 5; i++) sb_q.push_back(32'(i * 4));
        run(5, 1'b1);
        check("t2_retired", {16'd0, retired_cnt}, 32'd5);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Redirect to 8 while the head (pc 0) is being popped.
        do_reset();
        run(1, 1'b1);
        cyc(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, rd_s, addr_s, vld_s);
        check("t3_head_valid", {31'd0, vld_s}, 32'd1);
        check("t3_retired_hold", {16'd0, retired_cnt}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, rd_s, addr_s, vld_s);
        check("t3_flushed", {31'd0, vld_s}, 32'd0);
        check("t3_tgt_rd", {31'd0, rd_s}, 32'd1);
        check("t3_tgt_addr", addr_s, 32'h8);
        sb_q.push_back(32'h8);
        sb_q.push_back(32'hC);
        run(2, 1'b1);
        check("t3_retired", {16'd0, retired_cnt}, 32'd2);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Misaligned redirect faults; later redirects ignored.
        do_reset();
        sb_q.push_back(32'h0);
        run(2, 1'b1);
        cyc(1'b1, 1'b1, 32'h6, 1'b0, 1'b1, rd_s, addr_s, vld_s);
        check("t4_fault", {31'd0, fault}, 32'd1);
        check("t4_fault_addr", fault_addr, 32'h6);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, rd_s, addr_s, vld_s);
        check("t4_rd_off", {31'd0, rd_s}, 32'd0);
        check("t4_flushed", {31'd0, vld_s}, 32'd0);
        cyc(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, rd_s, addr_s, vld_s);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, rd_s, addr_s, vld_s);
        check("t4_redir_ignored_rd", {31'd0, rd_s}, 32'd0);
        check("t4_redir_ignored_valid", {31'd0, vld_s}, 32'd0);
        check("t4_fault_addr_kept", fault_addr, 32'h6);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Run off the end of the ROM window.
        do_reset();
        check("t5_fault_cleared", {31'd0, fault}, 32'd0);
        for (int i = 0; i < 32; i++) sb_q.push_back(32'(i * 4));
        run(36, 1'b1);
        check("t5_fault", {31'd0, fault}, 32'd1);
        check("t5_fault_addr", fault_addr, 32'h80);
        check("t5_retired", {16'd0, retired_cnt}, 32'd32);
        check("t5_rd_off", {31'd0, imem_rd}, 32'd0);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Halt drains the queue, resume at the held PC, then counter wrap.
        do_reset();
        for (int i = 0; i < 7; i++) sb_q.push_back(32'(i * 4));
        run(3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rd_s, addr_s, vld_s);
            check("t6_halt_rd", {31'd0, rd_s}, 32'd0);
        end
        check("t6_drained", {31'd0, vld_s}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, rd_s, addr_s, vld_s);
        check("t6_leave_halt_rd", {31'd0, rd_s}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, rd_s, addr_s, vld_s);
        check("t6_resume_rd", {31'd0, rd_s}, 32'd1);
        check("t6_resume_addr", addr_s, 32'h8);
        run(3, 1'b1);
        check("t6_retired", {16'd0, retired_cnt}, 32'd5);
        force dut.r_retired_cnt = 16'hFFFF;
        #1;
        release dut.r_retired_cnt;
        check("t6_preload", {16'd0, retired_cnt}, 32'h0000_FFFF);
        run(1, 1'b1);
        check("t6_wrap", {16'd0, retired_cnt}, 32'd0);
        run(1, 1'b1);
        check("t6_after_wrap", {16'd0, retired_cnt}, 32'd1);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
